riu_rd_sequencer: RTL and testbench
===================================

RIU_RD_SEQUENCER -- requirements
Module: riu_rd_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 63, meaning the max WAIT cycles before a read is aborted (range 1..255).
REQ-002 SHALL have parameter NIBBLE_CNT, default 8, meaning the number of XIPHY nibbles addressable, each with one select line.
REQ-003 SHALL have port riu_clk  input  1  the single clock; all logic is on its rising edge.
REQ-004 SHALL have port riu_rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port req_valid  input  1  host request present.
REQ-006 SHALL have port req_ready  output  1  sequencer accepts a request.
REQ-007 SHALL have port req_wr  input  1  1=write, 0=read.
REQ-008 SHALL have port req_nibble  input  8  target nibble index.
REQ-009 SHALL have port req_addr  input  6  RIU register address.
REQ-010 SHALL have port req_wdata  input  16  write data.
REQ-011 SHALL have port rsp_valid  output  1  response present.
REQ-012 SHALL have port rsp_ready  input  1  host consumes the response.
REQ-013 SHALL have port rsp_rdata  output  16  read data.
REQ-014 SHALL have port rsp_err  output  1  the access failed.
REQ-015 SHALL have port riu_addr  output  6  RIU address to the nibbles.
REQ-016 SHALL have port riu_wr_data  output  16  RIU write data.
REQ-017 SHALL have port riu_wr_en  output  1  RIU write strobe.
REQ-018 SHALL have port riu_nibble_sel  output  NIBBLE_CNT  one-hot nibble select.
REQ-019 SHALL have port riu_rd_data  input  16  ORed lower/upper nibble read data.
REQ-020 SHALL have port riu_valid  input  1  ORed lower/upper read valid.

Function
REQ-021 SHALL implement the states IDLE, ISSUE, WAIT and RESP; req_ready SHALL be 1 only in IDLE.
REQ-022 On a handshake (req_valid & req_ready), the block SHALL latch wr, nibble, addr and wdata and go to ISSUE the next cycle, or go to RESP with rsp_err=1 and rsp_rdata=0 if req_nibble >= NIBBLE_CNT, with no RIU access.
REQ-023 ISSUE SHALL last exactly 1 cycle, driving riu_nibble_sel one-hot at the latched nibble and riu_wr_en equal to the latched wr.
REQ-024 Outside ISSUE, riu_nibble_sel SHALL be all-zero and riu_wr_en 0; riu_addr and riu_wr_data SHALL hold their last latched values.
REQ-025 For a write, ISSUE SHALL go to RESP with rsp_err=0 and rsp_rdata=0.
REQ-026 For a read, ISSUE SHALL go to WAIT and clear the 8-bit wait counter.
REQ-027 In WAIT with riu_valid=1, the block SHALL capture riu_rd_data into rsp_rdata, set rsp_err=0 and go to RESP.
REQ-028 In WAIT with riu_valid=0, the wait counter SHALL increment; when it reaches TIMEOUT_CYCLES, the block SHALL go to RESP with rsp_err=1 and rsp_rdata=0 (timeout; see REQ-034).
REQ-029 If riu_valid=1 in the same cycle the timeout is reached, valid SHALL win and rsp_err SHALL be 0.
REQ-030 riu_valid in IDLE, ISSUE or RESP SHALL be ignored, with no state or data change.
REQ-031 In RESP, rsp_valid SHALL be 1 and rsp_rdata and rsp_err SHALL be stable until rsp_ready=1; the block SHALL then return to IDLE the next cycle.
REQ-032 Minimum read latency: request accepted in cycle 0, ISSUE in cycle 1, riu_valid in cycle 2, rsp_valid=1 in cycle 3; back-to-back accept is possible 1 cycle after the response handshake.

Reset
REQ-033 While riu_rst_n=0, the block SHALL immediately go to IDLE with all of the following at 0: req_ready, rsp_valid, rsp_rdata, rsp_err, riu_addr, riu_wr_data, riu_wr_en, riu_nibble_sel and the counter. req_ready SHALL rise in the first cycle after deassertion. A reset mid-transaction SHALL drop that transaction with no response.

Configuration
REQ-034 Macro RIU_SEQ_TIMEOUT_EN defined: the timeout of REQ-028/029 SHALL be present. Undefined: no counter; WAIT SHALL persist until riu_valid, and rsp_err SHALL only be set by REQ-022.

Verification
REQ-035 Read nibble 3, addr 0x0A; riu_valid=1 with data 0xBEEF 2 cycles later -> nibble_sel=0x08 for 1 cycle, rsp_rdata=0xBEEF, rsp_err=0, rsp_valid 3 cycles after accept.
REQ-036 Write nibble 0, addr 0x01, data 0x1234 -> riu_wr_en=1, nibble_sel=0x01, riu_wr_data=0x1234 for 1 cycle, then rsp_valid with rsp_err=0.
REQ-037 Read with riu_valid never asserted (macro defined, TIMEOUT_CYCLES=4) -> rsp_err=1 and rsp_rdata=0 after 4 WAIT cycles; valid asserted in the 4th WAIT cycle -> rsp_err=0.
REQ-038 req_nibble=9 -> no nibble_sel pulse, rsp_err=1 immediately; rsp_ready held 0 for 5 cycles -> rsp_rdata and rsp_err stable, req_ready=0.
REQ-039 riu_rst_n pulsed low during WAIT -> outputs zero at once, no rsp_valid, and a new read completes normally afterwards.

Source files
------------

// File: rtl/riu_rd_sequencer.sv
// -----------------------------------------------------------------------------
// riu_rd_sequencer
//
// Purpose:
//   Turns one host register request into one XIPHY RIU access. It selects one
//   nibble and issues a one-cycle RIU strobe. For a read it then waits for the
//   ORed riu_valid, and it returns a single response to the host.
//
// Optional feature (compile-time macro):
//   RIU_SEQ_TIMEOUT_EN  - when defined, a read that sees no riu_valid within
//                         TIMEOUT_CYCLES WAIT cycles ends with rsp_err=1.
//                         When undefined there is no counter, and WAIT lasts
//                         until riu_valid arrives.
//
// Parameters:
//   TIMEOUT_CYCLES  maximum WAIT cycles before a read is aborted (1..255)
//   NIBBLE_CNT      number of addressable nibbles / select lines (1..256)
//
// Ports:
//   riu_clk, riu_rst_n        clock (rising edge), async active-low reset
//   req_valid/req_ready       host request handshake
//   req_wr, req_nibble,
//   req_addr, req_wdata       request payload (1=write, nibble index, addr, data)
//   rsp_valid/rsp_ready       host response handshake
//   rsp_rdata, rsp_err        response payload
//   riu_addr, riu_wr_data     RIU address / write data (hold last latched value)
//   riu_wr_en                 RIU write strobe (ISSUE cycle only)
//   riu_nibble_sel            one-hot nibble select (ISSUE cycle only)
//   riu_rd_data, riu_valid    ORed read data / read valid from the nibbles
//   dbg_state                 current FSM state, for observation only
//
// Handshake rule (both host channels): a transfer happens on a rising edge
// where valid and ready are both 1. valid does not depend on ready. While
// valid=1 and ready=0, the payload is held stable.
// -----------------------------------------------------------------------------
module riu_rd_sequencer #(
    parameter int TIMEOUT_CYCLES = 63,
    parameter int NIBBLE_CNT     = 8
) (
    input  logic                  riu_clk,
    input  logic                  riu_rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wr,
    input  logic [7:0]            req_nibble,
    input  logic [5:0]            req_addr,
    input  logic [15:0]           req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [15:0]           rsp_rdata,
    output logic                  rsp_err,
    output logic [5:0]            riu_addr,
    output logic [15:0]           riu_wr_data,
    output logic                  riu_wr_en,
    output logic [NIBBLE_CNT-1:0] riu_nibble_sel,
    input  logic [15:0]           riu_rd_data,
    input  logic                  riu_valid,
    output logic [1:0]            dbg_state
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    // One bit wider than req_nibble, so that NIBBLE_CNT=256 still compares
    // correctly.
    localparam logic [8:0] NIB_LIMIT = 9'(NIBBLE_CNT);

    // Elaboration-time guard against unsupported parameter values.
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("riu_rd_sequencer: TIMEOUT_CYCLES must be in 1..255");
    end
    if (NIBBLE_CNT < 1 || NIBBLE_CNT > 256) begin : g_bad_nibble_cnt
        $error("riu_rd_sequencer: NIBBLE_CNT must be in 1..256");
    end

    logic [1:0]  state_q, state_d;
    logic        wr_q, wr_d;
    logic [7:0]  nib_q, nib_d;
    logic [5:0]  addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        req_hs;

`ifdef RIU_SEQ_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);
    logic [7:0]  cnt_q, cnt_d;
`endif

    // Gating with riu_rst_n keeps req_ready low while reset is held. It also
    // lets req_ready rise in the first cycle after reset is released.
    assign req_ready = (state_q == S_IDLE) && riu_rst_n;
    assign req_hs    = req_valid && req_ready;

    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        nib_d   = nib_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
`ifdef RIU_SEQ_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req_hs) begin
                    wr_d    = req_wr;
                    nib_d   = req_nibble;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    // A nibble with no select line is rejected here and never
                    // reaches the RIU.
                    if ({1'b0, req_nibble} >= NIB_LIMIT) begin
                        state_d = S_RESP;
                        rdata_d = 16'h0000;
                        err_d   = 1'b1;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (wr_q) begin
                    state_d = S_RESP;
                    rdata_d = 16'h0000;
                    err_d   = 1'b0;
                end else begin
                    state_d = S_WAIT;
`ifdef RIU_SEQ_TIMEOUT_EN
                    cnt_d   = 8'd0;
`endif
                end
            end
            S_WAIT: begin
                // riu_valid is tested first, so data that arrives in the
                // timeout cycle still produces a good response.
                if (riu_valid) begin
                    state_d = S_RESP;
                    rdata_d = riu_rd_data;
                    err_d   = 1'b0;
                end else begin
`ifdef RIU_SEQ_TIMEOUT_EN
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_d == TIMEOUT_LIMIT) begin
                        state_d = S_RESP;
                        rdata_d = 16'h0000;
                        err_d   = 1'b1;
                    end
`endif
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge riu_clk or negedge riu_rst_n) begin
        if (!riu_rst_n) begin
            state_q <= S_IDLE;
            wr_q    <= 1'b0;
            nib_q   <= 8'd0;
            addr_q  <= 6'd0;
            wdata_q <= 16'h0000;
            rdata_q <= 16'h0000;
            err_q   <= 1'b0;
`ifdef RIU_SEQ_TIMEOUT_EN
            cnt_q   <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            nib_q   <= nib_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
`ifdef RIU_SEQ_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    // The select is decoded only during ISSUE. In that state nib_q has already
    // been checked against NIBBLE_CNT.
    always_comb begin
        riu_nibble_sel = '0;
        if (state_q == S_ISSUE) begin
            for (int i = 0; i < NIBBLE_CNT; i++) begin
                riu_nibble_sel[i] = (nib_q == 8'(i));
            end
        end
    end

    assign riu_wr_en   = (state_q == S_ISSUE) && wr_q;
    assign riu_addr    = addr_q;
    assign riu_wr_data = wdata_q;
    assign rsp_valid   = (state_q == S_RESP);
    assign rsp_rdata   = rdata_q;
    assign rsp_err     = err_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_riu_rd_sequencer.sv
// -----------------------------------------------------------------------------
// tb_riu_rd_sequencer
//
// Bench for riu_rd_sequencer. The stimulus is transaction based. For each
// transaction, the expected outputs of every cycle are worked out from its
// schedule:
//   accept -> strobe cycle -> N read-wait cycles -> response until taken.
// A single compare process checks the DUT against those expectations in every
// cycle. Directed transactions also pin a few results to literal values.
// -----------------------------------------------------------------------------
module tb_riu_rd_sequencer;

    localparam int NIB_CNT = 8;
    localparam int TO_CYC  = 4;
`ifdef RIU_SEQ_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic               riu_clk = 1'b0;
    logic               riu_rst_n;
    logic               req_valid, req_ready, req_wr;
    logic [7:0]         req_nibble;
    logic [5:0]         req_addr;
    logic [15:0]        req_wdata;
    logic               rsp_valid, rsp_ready, rsp_err;
    logic [15:0]        rsp_rdata;
    logic [5:0]         riu_addr;
    logic [15:0]        riu_wr_data;
    logic               riu_wr_en;
    logic [NIB_CNT-1:0] riu_nibble_sel;
    logic [15:0]        riu_rd_data;
    logic               riu_valid;
    logic [1:0]         dbg_state;

    always #5 riu_clk = ~riu_clk;

    riu_rd_sequencer #(
        .TIMEOUT_CYCLES (TO_CYC),
        .NIBBLE_CNT     (NIB_CNT)
    ) dut (
        .riu_clk        (riu_clk),
        .riu_rst_n      (riu_rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_wr         (req_wr),
        .req_nibble     (req_nibble),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_rdata      (rsp_rdata),
        .rsp_err        (rsp_err),
        .riu_addr       (riu_addr),
        .riu_wr_data    (riu_wr_data),
        .riu_wr_en      (riu_wr_en),
        .riu_nibble_sel (riu_nibble_sel),
        .riu_rd_data    (riu_rd_data),
        .riu_valid      (riu_valid),
        .dbg_state      (dbg_state)
    );

    // ---------------- model / expectations ----------------
    int                 n_vec = 0;
    int                 n_err = 0;
    int                 cyc_n = 0;
    bit                 chk_en = 1'b0;
    logic               exp_ready, exp_rsp_valid, exp_wr_en, exp_err;
    logic               exp_chk_data;
    logic [NIB_CNT-1:0] exp_sel;
    logic [5:0]         exp_addr;
    logic [15:0]        exp_wdata, exp_rdata;
    logic [5:0]         m_addr;   // last address latched by a handshake
    logic [15:0]        m_wdata;  // last write data latched by a handshake

    // Observations for the literal checks (filled by the compare process)
    bit                 obs_on = 1'b0;
    int                 acc_cyc, obs_lat, obs_sel_cnt, obs_wen_cnt;
    logic [NIB_CNT-1:0] obs_sel_or;
    logic [15:0]        obs_rdata, obs_wdata;
    logic               obs_err;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h",
                     name, cyc_n, act, exp);
        end
    endtask

    // ---------------- compare process ----------------
    always begin
        @(posedge riu_clk);
        #3;
        cyc_n++;
        if (chk_en) begin
            check("req_ready", 32'(req_ready), 32'(exp_ready));
            check("rsp_valid", 32'(rsp_valid), 32'(exp_rsp_valid));
            check("nibble_sel", 32'(riu_nibble_sel), 32'(exp_sel));
            check("riu_wr_en", 32'(riu_wr_en), 32'(exp_wr_en));
            check("riu_addr", 32'(riu_addr), 32'(exp_addr));
            check("riu_wr_data", 32'(riu_wr_data), 32'(exp_wdata));
            if (exp_chk_data) begin
                check("rsp_rdata", 32'(rsp_rdata), 32'(exp_rdata));
                check("rsp_err", 32'(rsp_err), 32'(exp_err));
            end
        end
        if (obs_on) begin
            if (req_valid && req_ready && acc_cyc < 0) acc_cyc = cyc_n;
            obs_sel_or = obs_sel_or | riu_nibble_sel;
            if (riu_nibble_sel != '0) obs_sel_cnt++;
            if (riu_wr_en) begin
                obs_wen_cnt++;
                obs_wdata = riu_wr_data;
            end
            if (rsp_valid && acc_cyc >= 0 && obs_lat < 0) begin
                obs_lat   = cyc_n - acc_cyc;
                obs_rdata = rsp_rdata;
                obs_err   = rsp_err;
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic step();
        @(posedge riu_clk);
        #1;
    endtask

    task automatic noise();
        req_valid   = 1'($urandom_range(0, 1));
        req_wr      = 1'($urandom_range(0, 1));
        req_nibble  = 8'($urandom);
        req_addr    = 6'($urandom);
        req_wdata   = 16'($urandom);
        riu_valid   = 1'($urandom_range(0, 1));
        riu_rd_data = 16'($urandom);
        rsp_ready   = 1'($urandom_range(0, 1));
    endtask

    task automatic set_busy_exp(input logic ready);
        exp_ready     = ready;
        exp_rsp_valid = 1'b0;
        exp_sel       = '0;
        exp_wr_en     = 1'b0;
        exp_addr      = m_addr;
        exp_wdata     = m_wdata;
        exp_chk_data  = 1'b0;
        exp_rdata     = 16'h0;
        exp_err       = 1'b0;
    endtask

    task automatic set_reset_exp();
        m_addr  = 6'd0;
        m_wdata = 16'h0;
        set_busy_exp(1'b0);
        exp_chk_data = 1'b1;
    endtask

    // One complete host transaction, starting in IDLE. lat is the index of the
    // WAIT cycle in which riu_valid is driven (reads only). hold is the number
    // of response cycles with rsp_ready low before the response is taken.
    task automatic run_txn(input logic wr, input logic [7:0] nib,
                           input logic [5:0] addr, input logic [15:0] wdata,
                           input int lat, input int hold, input int pre_idle,
                           input logic [15:0] rd_val);
        logic [15:0] rd;
        logic        er;
        int          n_wait;
        obs_on = 1'b1; acc_cyc = -1; obs_lat = -1; obs_sel_cnt = 0;
        obs_wen_cnt = 0; obs_sel_or = '0; obs_rdata = 16'h0;
        obs_wdata = 16'h0; obs_err = 1'b0;
        for (int i = 0; i < pre_idle; i++) begin
            step(); noise(); req_valid = 1'b0; set_busy_exp(1'b1);
        end
        // accept cycle
        step(); noise();
        req_valid = 1'b1; req_wr = wr; req_nibble = nib;
        req_addr = addr; req_wdata = wdata;
        set_busy_exp(1'b1);
        m_addr = addr; m_wdata = wdata;
        if (nib >= 8'(NIB_CNT)) begin
            rd = 16'h0; er = 1'b1;
        end else begin
            // strobe cycle
            step(); noise(); set_busy_exp(1'b0);
            exp_sel   = NIB_CNT'(1) << nib;
            exp_wr_en = wr;
            if (wr) begin
                rd = 16'h0; er = 1'b0;
            end else begin
                if (TO_EN && lat >= TO_CYC) begin
                    n_wait = TO_CYC; rd = 16'h0; er = 1'b1;
                end else begin
                    n_wait = lat + 1; rd = rd_val; er = 1'b0;
                end
                for (int i = 0; i < n_wait; i++) begin
                    step(); noise(); set_busy_exp(1'b0);
                    riu_valid = (i == lat);
                    if (i == lat) riu_rd_data = rd_val;
                end
            end
        end
        // response cycles
        for (int i = 0; i <= hold; i++) begin
            step(); noise(); set_busy_exp(1'b0);
            rsp_ready     = (i == hold);
            exp_rsp_valid = 1'b1;
            exp_chk_data  = 1'b1;
            exp_rdata     = rd;
            exp_err       = er;
        end
    endtask

    task automatic rst_in_wait();
        step(); noise();
        req_valid = 1'b1; req_wr = 1'b0; req_nibble = 8'd2;
        req_addr = 6'h15; req_wdata = 16'h5555;
        set_busy_exp(1'b1);
        m_addr = 6'h15; m_wdata = 16'h5555;
        step(); noise(); set_busy_exp(1'b0); exp_sel = NIB_CNT'(4);
        for (int i = 0; i < 2; i++) begin
            step(); noise(); riu_valid = 1'b0; set_busy_exp(1'b0);
        end
        step(); noise(); riu_rst_n = 1'b0; set_reset_exp();
        step(); noise(); set_reset_exp();
        step(); noise(); riu_rst_n = 1'b1; req_valid = 1'b0; set_busy_exp(1'b1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [7:0] nib;
        int         r;
        riu_rst_n = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_nibble = 8'd0;
        req_addr = 6'd0; req_wdata = 16'h0; rsp_ready = 1'b0;
        riu_rd_data = 16'h0; riu_valid = 1'b0;
        m_addr = 6'd0; m_wdata = 16'h0;
        set_busy_exp(1'b0);
        #1 riu_rst_n = 1'b0;
        step(); noise(); set_reset_exp(); chk_en = 1'b1;
        step(); noise(); set_reset_exp();
        step(); noise(); riu_rst_n = 1'b1; req_valid = 1'b0; set_busy_exp(1'b1);

        // Read nibble 3, addr 0x0A, data returned in the first WAIT cycle
        run_txn(1'b0, 8'd3, 6'h0A, 16'h0, 0, 0, 0, 16'hBEEF);
        #4;
        check("lit_rd_sel", 32'(obs_sel_or), 32'h08);
        check("lit_rd_sel_cycles", 32'(obs_sel_cnt), 32'd1);
        check("lit_rd_rdata", 32'(obs_rdata), 32'hBEEF);
        check("lit_rd_err", 32'(obs_err), 32'd0);
        check("lit_rd_latency", 32'(obs_lat), 32'd3);

        // Write nibble 0, addr 0x01, data 0x1234 (accepted back-to-back)
        run_txn(1'b1, 8'd0, 6'h01, 16'h1234, 0, 0, 0, 16'h0);
        #4;
        check("lit_wr_sel", 32'(obs_sel_or), 32'h01);
        check("lit_wr_en_cycles", 32'(obs_wen_cnt), 32'd1);
        check("lit_wr_data", 32'(obs_wdata), 32'h1234);
        check("lit_wr_err", 32'(obs_err), 32'd0);
        check("lit_wr_latency", 32'(obs_lat), 32'd2);

        // Out-of-range nibble, response held for 5 cycles
        run_txn(1'b0, 8'd9, 6'h22, 16'h0, 0, 5, 1, 16'h0);
        #4;
        check("lit_badnib_sel_cycles", 32'(obs_sel_cnt), 32'd0);
        check("lit_badnib_err", 32'(obs_err), 32'd1);
        check("lit_badnib_rdata", 32'(obs_rdata), 32'h0);
        check("lit_badnib_latency", 32'(obs_lat), 32'd1);

        // Read whose data arrives late
        run_txn(1'b0, 8'd5, 6'h30, 16'h0, 10, 0, 1, 16'hC0DE);
        #4;
`ifdef RIU_SEQ_TIMEOUT_EN
        check("lit_timeout_err", 32'(obs_err), 32'd1);
        check("lit_timeout_rdata", 32'(obs_rdata), 32'h0);
        check("lit_timeout_latency", 32'(obs_lat), 32'd6);
        // data in the 4th WAIT cycle beats the timeout
        run_txn(1'b0, 8'd5, 6'h31, 16'h0, 3, 0, 1, 16'hA5A5);
        #4;
        check("lit_edge_err", 32'(obs_err), 32'd0);
        check("lit_edge_rdata", 32'(obs_rdata), 32'hA5A5);
        check("lit_edge_latency", 32'(obs_lat), 32'd6);
`else
        check("lit_late_err", 32'(obs_err), 32'd0);
        check("lit_late_rdata", 32'(obs_rdata), 32'hC0DE);
        check("lit_late_latency", 32'(obs_lat), 32'd13);
`endif

        // Reset during WAIT, then a normal read
        rst_in_wait();
        run_txn(1'b0, 8'd7, 6'h3F, 16'h0, 1, 0, 0, 16'h1357);
        #4;
        check("lit_post_rst_rdata", 32'(obs_rdata), 32'h1357);
        check("lit_post_rst_sel", 32'(obs_sel_or), 32'h80);
        obs_on = 1'b0;

        // Randomized traffic
        for (int t = 0; t < 80; t++) begin
            r = $urandom_range(0, 9);
            nib = (r == 9) ? 8'($urandom_range(8, 255)) : 8'(r);
            run_txn(1'($urandom_range(0, 1)), nib, 6'($urandom), 16'($urandom),
                    $urandom_range(0, 6), $urandom_range(0, 3),
                    $urandom_range(0, 2), 16'($urandom));
        end

        step(); noise(); req_valid = 1'b0; set_busy_exp(1'b1);
        step();
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
